// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//
// Brings up the board clock PLL and watches it afterwards. After power-up
// the PLL is held in reset for a fixed time. The sequencer then waits for
// lock and requires lock to stay up for a qualification window before it
// raises ready. ready gates the release of every downstream clock-domain
// reset.
//
// A lock loss while running, or a software restart request, starts the
// sequence again. If lock does not arrive within the timeout, the sequencer
// retries. When the retries are used up it parks in FAULT with the PLL held
// in reset, and it leaves FAULT only on a restart request or on rst_n.
//
// Ports
//   refclk       in   50 MHz board reference clock (the only clock)
//   rst_n        in   asynchronous active-low reset
//   pll_locked   in   PLL lock indicator, asynchronous to refclk
//   pll_rst      out  active-high reset to the PLL
//   ready        out  PLL locked and qualified; downstream resets may release
//   fault        out  retries exhausted; PLL held in reset
//   restart_req  in   one-cycle pulse requesting a fresh bring-up
//   restart_ack  out  one-cycle pulse on the first RUN cycle after a restart
//   retry_cnt    out  lock timeouts seen during the current bring-up
//   loss_cnt     out  saturating count of lock losses seen in RUN
//
// Build option
//   PLL_SEQ_LOSS_CNT_EN  when defined, loss_cnt is a real saturating counter.
//                        When undefined, no counter is built and loss_cnt
//                        reads 8'd0.
//
// All outputs are registered. They change on the same edge as the state
// transition that causes them.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       ready,
  output logic       fault,
  input  logic       restart_req,
  output logic       restart_ack,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  // One shared timer serves every state, so it is sized for the longest span.
  localparam int SPAN_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_SPAN = (SPAN_A > STABLE_CYCLES) ? SPAN_A : STABLE_CYCLES;
  localparam int TW       = $clog2(MAX_SPAN + 1);

  localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          sync_meta;
  logic          locked_s;
  logic          restart_pending;

  // Two-flop synchroniser for the asynchronous lock indicator.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      sync_meta <= pll_locked;
      locked_s  <= sync_meta;
    end
  end

`ifndef PLL_SEQ_LOSS_CNT_EN
  assign loss_cnt = 8'd0;
`endif

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_HOLD;
      timer           <= '0;
      pll_rst         <= 1'b1;
      ready           <= 1'b0;
      fault           <= 1'b0;
      restart_ack     <= 1'b0;
      retry_cnt       <= 4'd0;
      restart_pending <= 1'b0;
`ifdef PLL_SEQ_LOSS_CNT_EN
      loss_cnt        <= 8'd0;
`endif
    end else begin
      // restart_ack is a single-cycle pulse. It is raised only on RUN entry.
      restart_ack <= 1'b0;

      if (restart_req) begin
        // A restart overrides every event in the same cycle: a lock loss in
        // RUN is not counted, and a WAIT timeout is not counted as a retry.
        // If a restart is already pending, the flag simply stays set, so the
        // requester still gets exactly one ack.
        state           <= S_HOLD;
        timer           <= '0;
        pll_rst         <= 1'b1;
        ready           <= 1'b0;
        fault           <= 1'b0;
        retry_cnt       <= 4'd0;
        restart_pending <= 1'b1;
      end else begin
        case (state)
          S_HOLD: begin
            pll_rst <= 1'b1;
            if (timer == RST_LAST) begin
              state   <= S_WAIT;
              timer   <= '0;
              pll_rst <= 1'b0;
            end else begin
              timer <= timer + 1'b1;
            end
          end

          S_WAIT: begin
            if (locked_s) begin
              state <= S_STABLE;
              timer <= '0;
            end else if (timer == LOCK_LAST) begin
              timer   <= '0;
              pll_rst <= 1'b1;
              if (retry_cnt == RETRY_LIMIT) begin
                state <= S_FAULT;
                fault <= 1'b1;
              end else begin
                state     <= S_HOLD;
                retry_cnt <= retry_cnt + 4'd1;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end

          S_STABLE: begin
            // A glitch during qualification sends the sequencer back to WAIT.
            // The PLL is not reset, and the glitch is not a retry or a loss.
            if (!locked_s) begin
              state <= S_WAIT;
              timer <= '0;
            end else if (timer == STABLE_LAST) begin
              state     <= S_RUN;
              timer     <= '0;
              ready     <= 1'b1;
              retry_cnt <= 4'd0;
              if (restart_pending) begin
                restart_ack     <= 1'b1;
                restart_pending <= 1'b0;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end

          S_RUN: begin
            // ready drops and pll_rst rises on the same edge, so the two are
            // never high together.
            if (!locked_s) begin
              state   <= S_HOLD;
              timer   <= '0;
              ready   <= 1'b0;
              pll_rst <= 1'b1;
`ifdef PLL_SEQ_LOSS_CNT_EN
              if (loss_cnt != 8'hFF) begin
                loss_cnt <= loss_cnt + 8'd1;
              end
`endif
            end
          end

          S_FAULT: begin
            pll_rst <= 1'b1;
            fault   <= 1'b1;
            ready   <= 1'b0;
          end

          default: begin
            state   <= S_HOLD;
            timer   <= '0;
            pll_rst <= 1'b1;
            ready   <= 1'b0;
            fault   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Testbench for pll_lock_sequencer.
//
// Main DUT: RST_CYCLES=16, LOCK_TIMEOUT=8, STABLE_CYCLES=256, MAX_RETRIES=2.
// Fast DUT: short timings, used to force hundreds of lock losses.
//
// The PLL model reports lock whenever the test allows it and the PLL is not
// held in reset. Stimulus pushes the output events it expects, with their
// cycle numbers, into a queue. A monitor detects output edges and ack
// pulses, then pops the queue and compares the two.
module tb_pll_lock_sequencer;

  localparam int K_RST_RISE   = 0;
  localparam int K_RST_FALL   = 1;
  localparam int K_RDY_RISE   = 2;
  localparam int K_RDY_FALL   = 3;
  localparam int K_FAULT_RISE = 4;
  localparam int K_FAULT_FALL = 5;
  localparam int K_ACK        = 6;

  typedef struct {
    int kind;
    int cyc;
    int retry;
    int loss;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  viol     = 0;
  int  cyc      = 0;

  logic refclk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_fast_n = 1'b0;
  logic lock_en = 1'b1;
  logic lock_en_f = 1'b0;
  logic restart_req = 1'b0;
  logic restart_req_f = 1'b0;

  logic       pll_locked, pll_rst, ready, fault, restart_ack;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic       pll_locked_f, pll_rst_f, ready_f, fault_f, restart_ack_f;
  logic [3:0] retry_cnt_f;
  logic [7:0] loss_cnt_f;

  assign pll_locked   = lock_en & ~pll_rst;
  assign pll_locked_f = lock_en_f & ~pll_rst_f;

  always #10 refclk = ~refclk;

  always @(posedge refclk) if (rst_n) cyc <= cyc + 1;

  pll_lock_sequencer #(
    .RST_CYCLES(16), .LOCK_TIMEOUT(8), .STABLE_CYCLES(256), .MAX_RETRIES(2)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .ready(ready), .fault(fault),
    .restart_req(restart_req), .restart_ack(restart_ack),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  pll_lock_sequencer #(
    .RST_CYCLES(2), .LOCK_TIMEOUT(8), .STABLE_CYCLES(1), .MAX_RETRIES(3)
  ) dut_fast (
    .refclk(refclk), .rst_n(rst_fast_n), .pll_locked(pll_locked_f),
    .pll_rst(pll_rst_f), .ready(ready_f), .fault(fault_f),
    .restart_req(restart_req_f), .restart_ack(restart_ack_f),
    .retry_cnt(retry_cnt_f), .loss_cnt(loss_cnt_f)
  );

  function automatic int lexp(input int n);
`ifdef PLL_SEQ_LOSS_CNT_EN
    return (n > 255) ? 255 : n;
`else
    return 0 * n;
`endif
  endfunction

  function automatic string ev_name(input int k);
    case (k)
      K_RST_RISE:   return "pll_rst_rise";
      K_RST_FALL:   return "pll_rst_fall";
      K_RDY_RISE:   return "ready_rise";
      K_RDY_FALL:   return "ready_fall";
      K_FAULT_RISE: return "fault_rise";
      K_FAULT_FALL: return "fault_fall";
      K_ACK:        return "restart_ack";
      default:      return "none";
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_ev(input int kind, input int c, input int r, input int l);
    ev_t e;
    e.kind = kind; e.cyc = c; e.retry = r; e.loss = l;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind);
    ev_t e;
    $display("event %s at cycle %0d retry=%0d loss=%0d", ev_name(kind), cyc, retry_cnt, loss_cnt);
    if (exp_q.size() == 0) begin
      check($sformatf("unexpected %s", ev_name(kind)), kind, -1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("%s kind", ev_name(e.kind)), kind, e.kind);
      check($sformatf("%s cycle", ev_name(e.kind)), cyc, e.cyc);
      check($sformatf("%s retry_cnt", ev_name(e.kind)), int'(retry_cnt), e.retry);
      check($sformatf("%s loss_cnt", ev_name(e.kind)), int'(loss_cnt), e.loss);
    end
  endtask

  task automatic at(input int n);
    while (cyc < n) @(negedge refclk);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  logic p_rst, p_rdy, p_flt;
  initial begin
    p_rst = 1'b1; p_rdy = 1'b0; p_flt = 1'b0;
    wait (rst_n === 1'b1);
    forever begin
      @(negedge refclk);
      if (pll_rst && !p_rst) observe(K_RST_RISE);
      if (!pll_rst && p_rst) observe(K_RST_FALL);
      if (ready && !p_rdy)   observe(K_RDY_RISE);
      if (!ready && p_rdy)   observe(K_RDY_FALL);
      if (fault && !p_flt)   observe(K_FAULT_RISE);
      if (!fault && p_flt)   observe(K_FAULT_FALL);
      if (restart_ack)       observe(K_ACK);
      if (ready && (pll_rst || fault)) viol++;
      if (ready_f && (pll_rst_f || fault_f)) viol++;
      p_rst = pll_rst; p_rdy = ready; p_flt = fault;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit ok;
    // Reset state, while rst_n is still low.
    repeat (3) @(negedge refclk);
    check("reset pll_rst", int'(pll_rst), 1);
    check("reset ready", int'(ready), 0);
    check("reset fault", int'(fault), 0);
    check("reset restart_ack", int'(restart_ack), 0);
    check("reset retry_cnt", int'(retry_cnt), 0);
    check("reset loss_cnt", int'(loss_cnt), 0);

    // Power-up bring-up: ready 16+2+256+1 cycles after release.
    expect_ev(K_RST_FALL, 16, 0, 0);
    expect_ev(K_RDY_RISE, 275, 0, 0);
    rst_n = 1'b1;
    at(290);

    // Lock loss in RUN: lock dropped for 5 cycles.
    expect_ev(K_RST_RISE, 303, 0, lexp(1));
    expect_ev(K_RDY_FALL, 303, 0, lexp(1));
    expect_ev(K_RST_FALL, 319, 0, lexp(1));
    expect_ev(K_RDY_RISE, 578, 0, lexp(1));
    at(300); lock_en = 1'b0;
    at(305); lock_en = 1'b1;
    at(590);

    // Restart from RUN, then a one-cycle glitch during STABLE.
    expect_ev(K_RST_RISE, 600, 0, lexp(1));
    expect_ev(K_RDY_FALL, 600, 0, lexp(1));
    expect_ev(K_RST_FALL, 616, 0, lexp(1));
    expect_ev(K_RDY_RISE, 960, 0, lexp(1));
    expect_ev(K_ACK,      960, 0, lexp(1));
    at(599); restart_req = 1'b1;
    at(600); restart_req = 1'b0;
    at(700); lock_en = 1'b0;
    at(701); lock_en = 1'b1;
    at(990);

    // Restart coincident with lock loss in RUN: no loss counted.
    expect_ev(K_RST_RISE, 1003, 0, lexp(1));
    expect_ev(K_RDY_FALL, 1003, 0, lexp(1));
    expect_ev(K_RST_FALL, 1019, 0, lexp(1));
    expect_ev(K_RDY_RISE, 1278, 0, lexp(1));
    expect_ev(K_ACK,      1278, 0, lexp(1));
    at(1000); lock_en = 1'b0;
    at(1002); restart_req = 1'b1;
    at(1003); restart_req = 1'b0;
    at(1005); lock_en = 1'b1;
    at(1290);

    // Lock never returns: three attempts, then FAULT.
    expect_ev(K_RST_RISE,   1303, 0, lexp(2));
    expect_ev(K_RDY_FALL,   1303, 0, lexp(2));
    expect_ev(K_RST_FALL,   1319, 0, lexp(2));
    expect_ev(K_RST_RISE,   1327, 1, lexp(2));
    expect_ev(K_RST_FALL,   1343, 1, lexp(2));
    expect_ev(K_RST_RISE,   1351, 2, lexp(2));
    expect_ev(K_RST_FALL,   1367, 2, lexp(2));
    expect_ev(K_RST_RISE,   1375, 2, lexp(2));
    expect_ev(K_FAULT_RISE, 1375, 2, lexp(2));
    at(1300); lock_en = 1'b0;
    at(1390);
    check("fault held pll_rst", int'(pll_rst), 1);
    check("fault held fault", int'(fault), 1);

    // Restart out of FAULT, then a second restart mid-HOLD: one ack only.
    expect_ev(K_FAULT_FALL, 1400, 0, lexp(2));
    expect_ev(K_RST_FALL,   1424, 0, lexp(2));
    expect_ev(K_RDY_RISE,   1683, 0, lexp(2));
    expect_ev(K_ACK,        1683, 0, lexp(2));
    at(1395); lock_en = 1'b1;
    at(1399); restart_req = 1'b1;
    at(1400); restart_req = 1'b0;
    at(1407); restart_req = 1'b1;
    at(1408); restart_req = 1'b0;

    // Restart coincident with a WAIT timeout: retry_cnt stays 0.
    expect_ev(K_RST_RISE, 1703, 0, lexp(3));
    expect_ev(K_RDY_FALL, 1703, 0, lexp(3));
    expect_ev(K_RST_FALL, 1719, 0, lexp(3));
    expect_ev(K_RST_RISE, 1727, 0, lexp(3));
    expect_ev(K_RST_FALL, 1743, 0, lexp(3));
    expect_ev(K_RDY_RISE, 2002, 0, lexp(3));
    expect_ev(K_ACK,      2002, 0, lexp(3));
    at(1700); lock_en = 1'b0;
    at(1726); restart_req = 1'b1;
    at(1727); restart_req = 1'b0;
    at(1730); lock_en = 1'b1;
    at(2010);
    check("expected events left unmatched", exp_q.size(), 0);

    // Fast DUT: 300 forced lock losses.
    lock_en_f = 1'b1;
    rst_fast_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 300 && ok; i++) begin
      t = 0;
      while (!ready_f && t < 100) begin @(negedge refclk); t++; end
      if (!ready_f) begin
        check("fast ready within bound", 0, 1);
        ok = 1'b0;
      end else begin
        lock_en_f = 1'b0;
        t = 0;
        while (ready_f && t < 100) begin @(negedge refclk); t++; end
        if (ready_f) begin
          check("fast ready drop within bound", 1, 0);
          ok = 1'b0;
        end
        lock_en_f = 1'b1;
        if (i == 0) check("fast loss_cnt after first loss", int'(loss_cnt_f), lexp(1));
      end
    end
    t = 0;
    while (!ready_f && t < 100) begin @(negedge refclk); t++; end
    check("fast ready after losses", int'(ready_f), 1);
    check("fast loss_cnt after 300 losses", int'(loss_cnt_f), lexp(300));
    check("fast retry_cnt", int'(retry_cnt_f), 0);
    check("ready/pll_rst/fault overlap cycles", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences the clock PLL: holds it in reset after power-up, waits for lock and qualifies it as stable.
- Re-initialises the PLL on lock loss or on a software restart request, and retries with a timeout.
- Runs on the 50 MHz board reference clock, alongside the PLL it controls.
- Its ready output gates release of all downstream clock-domain resets (audio 6.144 MHz, 12 MHz, 1.5 MHz).

Parameters:
RST_CYCLES, 16, refclk cycles pll_rst is held high per attempt (>=2)
LOCK_TIMEOUT, 4096, refclk cycles allowed for lock after pll_rst release (>=4)
STABLE_CYCLES, 256, consecutive synchronised-locked cycles required before ready (>=1)
MAX_RETRIES, 3, timeouts tolerated before FAULT (0..15)

Ports:
refclk  in  1  reference clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
pll_locked  in  1  PLL lock indicator, asynchronous to refclk
pll_rst  out  1  active-high reset to PLL
ready  out  1  PLL locked and stable; downstream resets may release
fault  out  1  retries exhausted; PLL held in reset
restart_req  in  1  single-cycle pulse: request PLL re-initialisation
restart_ack  out  1  single-cycle pulse: requested restart completed
retry_cnt  out  4  timeouts in current bring-up
loss_cnt  out  8  saturating count of lock losses while in RUN

Behaviour:
- Reset (rst_n=0, async):
  - state=HOLD, pll_rst=1, ready=0, fault=0, restart_ack=0.
  - retry_cnt=0, loss_cnt=0, cycle timer=0, synchroniser flops=0, pending-restart flag=0.
- pll_locked passes a 2-flop synchroniser; locked_s below is the second flop's output (2-cycle latency).
- All outputs are registered. A state transition at edge N updates outputs at edge N.
- HOLD:
  - pll_rst=1; timer counts 0..RST_CYCLES-1.
  - At terminal count -> WAIT; timer cleared; pll_rst=0 from that edge.
- WAIT:
  - locked_s=1 -> STABLE, timer cleared.
  - Else at timer=LOCK_TIMEOUT-1:
    - retry_cnt==MAX_RETRIES -> FAULT.
    - Otherwise retry_cnt+1 and -> HOLD.
- STABLE:
  - locked_s=0 -> WAIT, timer cleared. This is not counted as a retry or a loss.
  - STABLE_CYCLES consecutive locked_s=1 -> RUN.
  - On entering RUN: ready=1, retry_cnt=0.
  - If the pending-restart flag is set: restart_ack pulses for exactly the first RUN cycle, and the flag clears.
- RUN:
  - locked_s=0 -> HOLD; ready=0 and pll_rst=1 on the same edge.
  - loss_cnt increments, saturating at 255.
- FAULT:
  - pll_rst=1, fault=1, ready=0.
  - Exit only via restart_req or rst_n.
- restart_req (pulse, any state) -> HOLD next edge.
  - Timer cleared, retry_cnt=0, fault=0, ready=0, pending-restart flag set.
  - In HOLD, the hold period is restarted.
- Simultaneous events:
  - restart_req in the same cycle as RUN lock loss: restart wins and loss_cnt does not increment.
  - restart_req in the same cycle as a WAIT timeout: restart wins and retry_cnt becomes 0.
- restart_req while a restart is already pending: the sequence restarts; only one restart_ack is produced.
- ready never asserts in the same cycle as pll_rst. fault and ready are mutually exclusive.
- Timer width is sized for the maximum of RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES. The timer never wraps; it is cleared on every transition.

Optional Feature:
PLL_SEQ_LOSS_CNT_EN
- Defined: loss_cnt is implemented as specified.
- Undefined: no counter register; loss_cnt is tied to 8'd0. All other behaviour is unchanged.

Test Plan:
- Power-up, pll_locked tied 1, defaults -> pll_rst=1 for 16 cycles. ready rises exactly 16+2+256+1 cycles after rst_n release. retry_cnt=0.
- pll_locked tied 0, LOCK_TIMEOUT=8, MAX_RETRIES=2 -> three HOLD/WAIT attempts. retry_cnt steps 1,2. fault=1 after the third timeout, with pll_rst=1 held.
- In RUN, drop pll_locked for 5 cycles -> ready falls 3 cycles after the drop, pll_rst=1 for 16 cycles, loss_cnt=1. Re-lock restores ready.
- In STABLE, a 1-cycle pll_locked glitch low -> returns to WAIT, restarts the 256-cycle qualification, retry_cnt unchanged.
- restart_req in FAULT -> fault=0, full bring-up, single restart_ack on the first RUN cycle. A second restart_req mid-HOLD still yields one ack.
- restart_req coincident with lock loss in RUN -> loss_cnt unchanged. With the macro undefined, loss_cnt stays 0 through 300 forced losses.
